// File: rtl/lsu_mem_master.sv
// Load/store initiator between the RV32 execute stage and a word-organised data memory.
// Sub-word stores use read-modify-write; bad requests are answered with an error and never reach memory.
module lsu_mem_master #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned BYTE_SPACE_W = ADDR_W + 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              req_err_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       load_ext_c;
    logic [31:0]       merge_c;

    // Request legality: funct3, natural alignment and address range
    always_comb begin
        req_err_c = 1'b0;
        if (req_we) begin
            if (!(req_funct3 inside {F3_B, F3_H, F3_W})) req_err_c = 1'b1;
        end else begin
            if (!(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) req_err_c = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err_c = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err_c = 1'b1;
        if ((req_addr >> BYTE_SPACE_W) != 32'd0) req_err_c = 1'b1;
    end

    // Load lane extraction and extension
    always_comb begin
        case (off_q)
            2'd0:    byte_c = mem_rdata[7:0];
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_ext_c = {{24{byte_c[7]}}, byte_c};
            F3_H:    load_ext_c = {{16{half_c[15]}}, half_c};
            F3_BU:   load_ext_c = {24'd0, byte_c};
            F3_HU:   load_ext_c = {16'd0, half_c};
            default: load_ext_c = mem_rdata;
        endcase
    end

    // Sub-word store merge into the word just read
    always_comb begin
        merge_c = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (off_q)
                2'd0:    merge_c[7:0]   = wdata_q[7:0];
                2'd1:    merge_c[15:8]  = wdata_q[7:0];
                2'd2:    merge_c[23:16] = wdata_q[7:0];
                default: merge_c[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_c[31:16] = wdata_q[15:0];
        end else begin
            merge_c[15:0] = wdata_q[15:0];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[ADDR_W+1:2];
                    if (req_err_c) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d     = WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                state_d     = RESP;
                rsp_rdata_d = load_ext_c;
                rsp_err_d   = 1'b0;
            end
            RMW_RD: begin
                state_d     = RMW_WR;
                mem_wdata_d = merge_c;
            end
            WRITE, RMW_WR: begin
                state_d     = RESP;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Strobes decode registered state; rst_n gating kills a write in the reset cycle
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_read  = rst_n && (state_q == LOAD  || state_q == RMW_RD);
    assign mem_write = rst_n && (state_q == WRITE || state_q == RMW_WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
